cache_fill_ctrl: RTL and testbench
==================================

Name: cache_fill_ctrl

Overview:
Parametrised line-fill controller shared by NUM_CH cache requesters (I-cache, D-cache, later a prefetch or second core) and one word-wide memory.
- Arbitrates among pending misses, either fixed-priority or round-robin.
- Latches the winning line address and issues BLOCK_WORDS word reads.
- Steers returned words into the granted cache's data array, then writes its tag.
- Replaces the fixed two-cache, fixed-8-word fill FSM. Unlike it, the fill tolerates arbitrary memory latency and gaps in returned data.

Parameters:
NUM_CH, 2, number of requesting caches (channel 0 = I-cache, 1 = D-cache by convention).
ADDR_W, 16, byte-address width.
BLOCK_WORDS, 8, words per cache line (power of 2, >= 2).
WORD_BYTES, 2, bytes per memory word (power of 2).
RR_MODE, 0, arbitration: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
miss_req  in  NUM_CH  per-channel miss-detected level from each cache.
miss_addr  in  NUM_CH*ADDR_W  per-channel miss byte address; channel i occupies bits [i*ADDR_W +: ADDR_W].
mem_data_valid  in  1  memory returns one word this cycle.
mem_rd_en  out  1  read request strobe to memory.
mem_addr  out  ADDR_W  read word address; all-ones when mem_rd_en = 0.
stall  out  NUM_CH  per-channel pipeline stall.
data_we  out  NUM_CH  data-array write enable, one-hot to the granted channel.
tag_we  out  NUM_CH  tag-array write enable, one-hot.
fill_word_idx  out  log2(BLOCK_WORDS)  word offset of the word being written by data_we.
busy  out  1  fill in progress (state != IDLE).

Behaviour:
- Reset:
  - State IDLE; issue_cnt = 0, ret_cnt = 0, grant = 0.
  - mem_rd_en = 0, mem_addr = all-ones, data_we = 0, tag_we = 0, fill_word_idx = 0, busy = 0.
  - RR pointer = 0.
- Offset bits: OFF = log2(BLOCK_WORDS*WORD_BYTES). Line address = miss_addr[ADDR_W-1:OFF].
- stall[i] = miss_req[i], combinational in all states. Each cache drops miss_req after its tag write makes the access hit.
- IDLE:
  - If any miss_req is set, the arbiter picks a winner. grant and line_addr are registered; next state is FILL.
  - First mem_rd_en occurs 1 cycle after miss_req is seen.
  - Fixed mode: lowest set index wins.
  - RR mode: first set index at or after the pointer, wrapping. The pointer becomes grant+1 (mod NUM_CH) on grant.
- FILL:
  - While issue_cnt < BLOCK_WORDS:
    - mem_rd_en = 1.
    - mem_addr = {line_addr, issue_cnt[log2(BLOCK_WORDS)-1:0], log2(WORD_BYTES) zero bits}.
    - issue_cnt increments each cycle.
    - Afterwards mem_rd_en = 0.
  - On each mem_data_valid while ret_cnt < BLOCK_WORDS:
    - data_we[grant] = 1 and fill_word_idx = ret_cnt; ret_cnt increments.
  - When the BLOCK_WORDS-th valid is accepted, next state is TAG.
- TAG: tag_we[grant] = 1 for exactly one cycle. Counters clear; next state is IDLE.
- The mandatory IDLE cycle after TAG lets the cache re-evaluate miss_req before the next arbitration.
- Boundary conditions:
  - mem_data_valid in IDLE or TAG, or beyond BLOCK_WORDS: ignored, no data_we.
  - Valid returned in the same cycle as an issue: both proceed.
  - Gaps between valids: FILL waits indefinitely. No timeout.
  - Granted channel drops miss_req mid-fill: the fill completes from latched line_addr and the tag is still written.
  - A new miss on another channel during a fill: stalls until the next IDLE arbitration.
  - rst mid-fill: abort immediately to reset values. The partially filled line has no tag write, so it stays invalid.
  - Counters are log2(BLOCK_WORDS)+1 bits wide, so they never wrap.

Decomposition:
- Package cache_fill_pkg:
  - State encoding IDLE/FILL/TAG.
  - Localparams OFF, IDX_W = log2(BLOCK_WORDS), CH_W = log2(NUM_CH) (minimum 1).
- One sub-module, fill_arbiter (NUM_CH, RR_MODE): request vector in; grant index, grant_valid and pointer update out.

Test Plan:
1. Single miss on ch1 at 0x1234, memory latency 3 -> grant = 1; mem_addr 0x1230, 0x1232 … 0x123E on 8 consecutive cycles; data_we[1] on 8 valids with fill_word_idx 0..7; then one tag_we[1] pulse; busy falls.
2. ch0 and ch1 miss together, RR_MODE = 0 -> ch0 filled first, ch1 granted in the IDLE after its TAG. RR_MODE = 1 with both held across fills -> grants alternate 0, 1, 0.
3. rst asserted after 3 valids -> next cycle all outputs at reset values; further mem_data_valid pulses produce no data_we or tag_we.
4. Granted ch0 drops miss_req after 2 issues -> all 8 addresses are still issued, 8 data_we[0] and tag_we[0] occur.
5. Valids gapped 1-of-3 cycles plus 2 spurious valids in IDLE -> exactly 8 data_we in order 0..7; spurious valids ignored; TAG follows the 8th.
6. NUM_CH = 4, BLOCK_WORDS = 4, miss on ch3 at 0xABCD -> addresses 0xABC8, 0xABCA, 0xABCC, 0xABCE; tag_we = 4'b1000.

Source files
------------

// File: rtl/cache_fill_pkg.sv
// cache_fill_pkg
//   Shared types and width helpers for the cache line-fill controller.
//   - fill_state_t : controller state encoding (IDLE / FILL / TAG).
//   - calc_off     : byte-offset bits of a cache line, log2(BLOCK_WORDS*WORD_BYTES).
//   - calc_idx_w   : word-index width inside a line, log2(BLOCK_WORDS).
//   - calc_ch_w    : channel-index width, log2(NUM_CH) but never below 1.
package cache_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } fill_state_t;

    function automatic int calc_off(input int block_words, input int word_bytes);
        return $clog2(block_words * word_bytes);
    endfunction

    function automatic int calc_idx_w(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int calc_ch_w(input int num_ch);
        return (num_ch < 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/fill_arbiter.sv
// fill_arbiter
//   Combinational arbiter choosing which pending miss gets the next line fill.
//   RR_MODE = 0 : lowest set request index wins (ptr ignored).
//   RR_MODE = 1 : first set index at or after ptr wins, wrapping around.
// Ports:
//   req         in  NUM_CH  pending miss per channel
//   ptr         in  CH_W    round-robin start position
//   grant_idx   out CH_W    winning channel (0 when nothing is pending)
//   grant_valid out 1       at least one request is pending
//   ptr_next    out CH_W    grant_idx + 1 modulo NUM_CH, loaded on a grant
module fill_arbiter
    import cache_fill_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int RR_MODE = 0,
    parameter int CH_W    = calc_ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_valid,
    output logic [CH_W-1:0]   ptr_next
);

    always_comb begin
        int idx;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        // Scan channels in priority order; the first pending one found wins.
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (RR_MODE != 0) ? ((int'(ptr) + k) % NUM_CH) : k;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(idx);
            end
        end
    end

    assign ptr_next = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + CH_W'(1);

endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl
//   Line-fill controller shared by NUM_CH caches and one word-wide memory.
//   An arbiter picks a pending miss in IDLE; the line address and channel are
//   latched, BLOCK_WORDS word reads are issued back to back, returned words are
//   steered to the granted data array in return order, then the tag is written.
//   Memory latency and gaps between returned words are arbitrary.
//
//   Handshake: mem_rd_en is a one-cycle request strobe per word with no ready;
//   memory answers each request, in order, with one mem_data_valid pulse some
//   cycles later. Valids outside FILL or beyond the line are dropped.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   miss_req        per-channel miss level (also drives stall directly)
//   miss_addr       per-channel byte address, channel i at [i*ADDR_W +: ADDR_W]
//   mem_data_valid  memory returns one word this cycle
//   mem_rd_en       read strobe; mem_addr is the word address (all-ones when idle)
//   stall           per-channel pipeline stall
//   data_we         one-hot data-array write to the granted channel
//   tag_we          one-hot tag-array write, single cycle at the end of a fill
//   fill_word_idx   word offset written by data_we
//   busy            a fill is in progress
//   dbg_state       current controller state
module cache_fill_ctrl
    import cache_fill_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int WORD_BYTES  = 2,
    parameter int RR_MODE     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              miss_req,
    input  logic [NUM_CH*ADDR_W-1:0]       miss_addr,
    input  logic                           mem_data_valid,
    output logic                           mem_rd_en,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [NUM_CH-1:0]              stall,
    output logic [NUM_CH-1:0]              data_we,
    output logic [NUM_CH-1:0]              tag_we,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
    output logic                           busy,
    output fill_state_t                    dbg_state
);

    localparam int OFF    = calc_off(BLOCK_WORDS, WORD_BYTES);
    localparam int IDX_W  = calc_idx_w(BLOCK_WORDS);
    localparam int CH_W   = calc_ch_w(NUM_CH);
    localparam int WB_W   = $clog2(WORD_BYTES);
    localparam int LINE_W = ADDR_W - OFF;
    // One extra bit so a counter can hold BLOCK_WORDS itself without wrapping.
    localparam int CNT_W  = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

    fill_state_t        state, state_next;
    logic [CNT_W-1:0]   issue_cnt, ret_cnt;
    logic [CH_W-1:0]    grant, rr_ptr;
    logic [LINE_W-1:0]  line_addr;

    logic [CH_W-1:0]    arb_grant, arb_ptr_next;
    logic               arb_valid;
    logic [LINE_W-1:0]  win_line;

    fill_arbiter #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE),
        .CH_W    (CH_W)
    ) u_arb (
        .req         (miss_req),
        .ptr         (rr_ptr),
        .grant_idx   (arb_grant),
        .grant_valid (arb_valid),
        .ptr_next    (arb_ptr_next)
    );

    // Line-address bits of the arbitration winner only.
    assign win_line  = miss_addr[arb_grant*ADDR_W + OFF +: LINE_W];

    assign stall     = miss_req;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_next    = state;
        mem_rd_en     = 1'b0;
        mem_addr      = '1;
        data_we       = '0;
        tag_we        = '0;
        fill_word_idx = '0;
        case (state)
            IDLE: begin
                if (arb_valid) state_next = FILL;
            end
            FILL: begin
                // Issue and return run independently, so both may fire together.
                if (issue_cnt < CNT_FULL) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = ADDR_W'({line_addr, issue_cnt[IDX_W-1:0]}) << WB_W;
                end
                if (mem_data_valid && (ret_cnt < CNT_FULL)) begin
                    data_we[grant] = 1'b1;
                    fill_word_idx  = ret_cnt[IDX_W-1:0];
                    if (ret_cnt == CNT_LAST) state_next = TAG;
                end
            end
            TAG: begin
                tag_we[grant] = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            grant     <= '0;
            line_addr <= '0;
            rr_ptr    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant     <= arb_grant;
                        line_addr <= win_line;
                        rr_ptr    <= arb_ptr_next;
                    end
                end
                FILL: begin
                    if (mem_rd_en) issue_cnt <= issue_cnt + CNT_W'(1);
                    if (|data_we)  ret_cnt   <= ret_cnt + CNT_W'(1);
                end
                TAG: begin
                    issue_cnt <= '0;
                    ret_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl
//   Three controller instances: A (2 ch, 8 words, fixed priority), B (2 ch,
//   8 words, round-robin) and C (4 ch, 4 words, fixed priority). One memory
//   responder and one scoreboard serve whichever instance `sel` points at.
module tb_cache_fill_ctrl;
    import cache_fill_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    logic mem_valid;

    // ---------------- DUT signals ----------------
    logic [1:0]  a_miss, a_stall, a_we, a_tag;
    logic [31:0] a_addr;
    logic        a_rd_en, a_busy;
    logic [15:0] a_mem_addr;
    logic [2:0]  a_idx;
    fill_state_t a_state;

    logic [1:0]  b_miss, b_stall, b_we, b_tag;
    logic [31:0] b_addr;
    logic        b_rd_en, b_busy;
    logic [15:0] b_mem_addr;
    logic [2:0]  b_idx;
    fill_state_t b_state;

    logic [3:0]  c_miss, c_stall, c_we, c_tag;
    logic [63:0] c_addr;
    logic        c_rd_en, c_busy;
    logic [15:0] c_mem_addr;
    logic [1:0]  c_idx;
    fill_state_t c_state;

    cache_fill_ctrl #(.NUM_CH(2), .ADDR_W(16), .BLOCK_WORDS(8), .WORD_BYTES(2), .RR_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .miss_req(a_miss), .miss_addr(a_addr), .mem_data_valid(mem_valid),
        .mem_rd_en(a_rd_en), .mem_addr(a_mem_addr), .stall(a_stall), .data_we(a_we),
        .tag_we(a_tag), .fill_word_idx(a_idx), .busy(a_busy), .dbg_state(a_state));

    cache_fill_ctrl #(.NUM_CH(2), .ADDR_W(16), .BLOCK_WORDS(8), .WORD_BYTES(2), .RR_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .miss_req(b_miss), .miss_addr(b_addr), .mem_data_valid(mem_valid),
        .mem_rd_en(b_rd_en), .mem_addr(b_mem_addr), .stall(b_stall), .data_we(b_we),
        .tag_we(b_tag), .fill_word_idx(b_idx), .busy(b_busy), .dbg_state(b_state));

    cache_fill_ctrl #(.NUM_CH(4), .ADDR_W(16), .BLOCK_WORDS(4), .WORD_BYTES(2), .RR_MODE(0)) dut_c (
        .clk(clk), .rst(rst), .miss_req(c_miss), .miss_addr(c_addr), .mem_data_valid(mem_valid),
        .mem_rd_en(c_rd_en), .mem_addr(c_mem_addr), .stall(c_stall), .data_we(c_we),
        .tag_we(c_tag), .fill_word_idx(c_idx), .busy(c_busy), .dbg_state(c_state));

    // ---------------- selected-instance view ----------------
    int          sel;
    logic        m_rd_en, m_busy;
    logic [15:0] m_addr;
    logic [3:0]  m_we, m_idx, m_tag, m_stall, m_miss;
    logic [1:0]  m_state;

    always_comb begin
        m_rd_en = 1'b0; m_addr = '0; m_we = '0; m_idx = '0; m_tag = '0;
        m_busy = 1'b0; m_stall = '0; m_miss = '0; m_state = '0;
        case (sel)
            0: begin
                m_rd_en = a_rd_en; m_addr = a_mem_addr; m_we = {2'b0, a_we}; m_idx = {1'b0, a_idx};
                m_tag = {2'b0, a_tag}; m_busy = a_busy; m_stall = {2'b0, a_stall};
                m_miss = {2'b0, a_miss}; m_state = a_state;
            end
            1: begin
                m_rd_en = b_rd_en; m_addr = b_mem_addr; m_we = {2'b0, b_we}; m_idx = {1'b0, b_idx};
                m_tag = {2'b0, b_tag}; m_busy = b_busy; m_stall = {2'b0, b_stall};
                m_miss = {2'b0, b_miss}; m_state = b_state;
            end
            default: begin
                m_rd_en = c_rd_en; m_addr = c_mem_addr; m_we = c_we; m_idx = {2'b0, c_idx};
                m_tag = c_tag; m_busy = c_busy; m_stall = c_stall; m_miss = c_miss; m_state = c_state;
            end
        endcase
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [15:0] exp_addr_q[$];
    logic [7:0]  exp_we_q[$];    // {one-hot channel, word index}
    logic [3:0]  exp_tag_q[$];
    int cyc = 0;
    int rd_cnt = 0, we_cnt = 0, tag_cnt = 0;
    int last_rd_cyc = 0, last_we_cyc = 0, last_tag_cyc = 0;
    logic mon_en;

    task automatic expect_fill(input int ch, input logic [15:0] addr, input int bw);
        logic [15:0] line;
        line = addr & ~16'(bw * 2 - 1);
        for (int i = 0; i < bw; i++) begin
            exp_addr_q.push_back(line + 16'(2 * i));
            exp_we_q.push_back({4'(1 << ch), 4'(i)});
        end
        exp_tag_q.push_back(4'(1 << ch));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("stall", m_stall, m_miss);
            if (m_rd_en) begin
                rd_cnt++;
                last_rd_cyc = cyc;
                if (exp_addr_q.size() == 0) check("rd_en_extra", m_rd_en, 1'b0);
                else check("mem_addr", m_addr, exp_addr_q.pop_front());
            end else begin
                check("mem_addr_idle", m_addr, 16'hFFFF);
            end
            if (m_we != 4'b0) begin
                we_cnt++;
                last_we_cyc = cyc;
                if (exp_we_q.size() == 0) check("data_we_extra", m_we, 4'b0);
                else check("data_we_idx", {m_we, m_idx}, exp_we_q.pop_front());
            end
            if (m_tag != 4'b0) begin
                tag_cnt++;
                last_tag_cyc = cyc;
                if (exp_tag_q.size() == 0) check("tag_we_extra", m_tag, 4'b0);
                else check("tag_we", m_tag, exp_tag_q.pop_front());
            end
        end
    end

    // ---------------- memory responder ----------------
    int rd_q[$];
    int lat = 3;
    int gap_n = 1;
    int spur_cnt = 0;

    initial begin
        logic pop, spur_now;
        mem_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (m_rd_en) rd_q.push_back(cyc);
            @(posedge clk);
            #1;
            cyc++;
            pop = (rd_q.size() > 0) && (cyc - rd_q[0] >= lat) && (cyc % gap_n == 0);
            if (pop) void'(rd_q.pop_front());
            spur_now = 1'b0;
            if (spur_cnt > 0) begin
                spur_now = 1'b1;
                spur_cnt--;
            end
            mem_valid = pop || spur_now;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic raise_miss(input int ch, input logic [15:0] addr);
        case (sel)
            0: begin a_addr[ch*16 +: 16] = addr; a_miss[ch] = 1'b1; end
            1: begin b_addr[ch*16 +: 16] = addr; b_miss[ch] = 1'b1; end
            default: begin c_addr[ch*16 +: 16] = addr; c_miss[ch] = 1'b1; end
        endcase
    endtask

    task automatic drop_miss(input int ch);
        case (sel)
            0: a_miss[ch] = 1'b0;
            1: b_miss[ch] = 1'b0;
            default: c_miss[ch] = 1'b0;
        endcase
    endtask

    // which: 0 = reads issued, 1 = data writes, 2 = tag writes. Returns #1 after a posedge.
    task automatic wait_count(input string tag, input int which, input int target);
        int n, cur;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            cur = (which == 0) ? rd_cnt : (which == 1) ? we_cnt : tag_cnt;
        end while (cur < target && n < 400);
        #1;
        check(tag, cur, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, m_rd_en, 1'b0);
        check({tag, "_mem_addr"}, m_addr, 16'hFFFF);
        check({tag, "_data_we"}, m_we, 4'b0);
        check({tag, "_tag_we"}, m_tag, 4'b0);
        check({tag, "_word_idx"}, m_idx, 4'b0);
        check({tag, "_busy"}, m_busy, 1'b0);
        check({tag, "_state"}, m_state, 2'd0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_addr_left"}, exp_addr_q.size(), 0);
        check({tag, "_we_left"}, exp_we_q.size(), 0);
        check({tag, "_tag_left"}, exp_tag_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t_start, we_base, tag_base;
        rst = 1'b1; sel = 0; mon_en = 1'b0;
        a_miss = '0; b_miss = '0; c_miss = '0;
        a_addr = '0; b_addr = '0; c_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            @(negedge clk);
            check_reset_outputs("reset");
        end
        @(posedge clk); #1;
        sel = 0; mon_en = 1'b1;

        // 1: single miss on ch1, latency 3
        lat = 3;
        expect_fill(1, 16'h1234, 8);
        raise_miss(1, 16'h1234);
        @(negedge clk); check("t1_rd_before_grant", m_rd_en, 1'b0);
        @(negedge clk); check("t1_first_rd", m_rd_en, 1'b1);
        t_start = cyc;
        wait_count("t1_tag_count", 2, tag_cnt + 1);
        drop_miss(1);
        @(negedge clk); check("t1_busy_fall", m_busy, 1'b0);
        check("t1_issue_span", last_rd_cyc - t_start, 7);
        check("t1_tag_after_8th", last_tag_cyc - last_we_cyc, 1);
        check_drained("t1");
        @(posedge clk); #1;

        // 2a: simultaneous misses, fixed priority
        expect_fill(0, 16'h4000, 8);
        expect_fill(1, 16'h5006, 8);
        raise_miss(0, 16'h4000);
        raise_miss(1, 16'h5006);
        wait_count("t2a_tag0", 2, tag_cnt + 1);
        drop_miss(0);
        @(negedge clk); check("t2a_idle_between", m_busy, 1'b0);
        @(negedge clk); check("t2a_ch1_start", m_rd_en, 1'b1);
        wait_count("t2a_tag1", 2, tag_cnt + 1);
        drop_miss(1);
        @(negedge clk); check("t2a_busy", m_busy, 1'b0);
        check_drained("t2a");
        @(posedge clk); #1;

        // 2b: round-robin instance, both held for three fills
        sel = 1;
        expect_fill(0, 16'h6000, 8);
        expect_fill(1, 16'h7010, 8);
        expect_fill(0, 16'h6000, 8);
        raise_miss(0, 16'h6000);
        raise_miss(1, 16'h7010);
        wait_count("t2b_tags", 2, tag_cnt + 3);
        drop_miss(0);
        drop_miss(1);
        @(negedge clk); check("t2b_busy", m_busy, 1'b0);
        check_drained("t2b");
        @(posedge clk); #1;

        // 3: reset after three returned words
        sel = 0;
        expect_fill(0, 16'h8000, 8);
        raise_miss(0, 16'h8000);
        wait_count("t3_three_we", 1, we_cnt + 3);
        rst = 1'b1;
        drop_miss(0);
        mon_en = 1'b0;
        exp_addr_q.delete(); exp_we_q.delete(); exp_tag_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        we_base = we_cnt; tag_base = tag_cnt;
        @(negedge clk); check_reset_outputs("t3");
        repeat (20) @(posedge clk);
        #1;
        check("t3_no_we_after_rst", we_cnt, we_base);
        check("t3_no_tag_after_rst", tag_cnt, tag_base);
        check("t3_mem_leftovers", rd_q.size(), 0);

        // 4: granted ch0 drops its miss after two issues
        expect_fill(0, 16'h9ABC, 8);
        raise_miss(0, 16'h9ABC);
        wait_count("t4_two_issues", 0, rd_cnt + 2);
        drop_miss(0);
        wait_count("t4_tag", 2, tag_cnt + 1);
        @(negedge clk); check("t4_busy", m_busy, 1'b0);
        check_drained("t4");
        @(posedge clk); #1;

        // 5: spurious valids in IDLE, then gapped returns
        gap_n = 3;
        we_base = we_cnt;
        spur_cnt = 2;
        repeat (6) @(posedge clk);
        #1;
        check("t5_spur_sent", spur_cnt, 0);
        check("t5_spur_ignored", we_cnt, we_base);
        expect_fill(1, 16'hC3F2, 8);
        raise_miss(1, 16'hC3F2);
        wait_count("t5_tag", 2, tag_cnt + 1);
        drop_miss(1);
        check("t5_tag_after_8th", last_tag_cyc - last_we_cyc, 1);
        check("t5_we_total", we_cnt - we_base, 8);
        @(negedge clk); check("t5_busy", m_busy, 1'b0);
        check_drained("t5");
        gap_n = 1;
        @(posedge clk); #1;

        // 6: four channels, four-word lines, miss on ch3
        sel = 2;
        @(posedge clk); #1;
        expect_fill(3, 16'hABCD, 4);
        raise_miss(3, 16'hABCD);
        wait_count("t6_tag", 2, tag_cnt + 1);
        drop_miss(3);
        @(negedge clk); check("t6_busy", m_busy, 1'b0);
        check_drained("t6");

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
